// File: rtl/updown_counter_fsm.sv
// -----------------------------------------------------------------------------
// updown_counter_fsm
//
// Parametrised up/down counter with a small control FSM. It counts over the
// range 0..MAX, supports a synchronous parallel load, wraps or saturates at the
// range boundaries, and presents the count in binary or Gray coding. A
// registered terminal-count pulse marks the cycle after each landing on the
// terminal value for the current direction.
//
// Parameters:
//   WIDTH    - counter width in bits (>= 2)
//   MAX      - highest count value, MAX <= 2**WIDTH-1
//   SATURATE - 0: wrap at the boundaries, 1: hold at the boundary and HALT
//
// Ports:
//   clk   in  1      rising-edge clock
//   reset in  1      synchronous, active-high reset
//   en    in  1      count enable, one step per cycle
//   P     in  1      direction, 0 = up, 1 = down
//   load  in  1      synchronous parallel load strobe
//   d     in  WIDTH  load value, clamped to MAX
//   gray  in  1      output coding, 0 = binary, 1 = Gray
//   y     out WIDTH  count value in the selected coding
//   tc    out 1      registered terminal-count pulse
//   st    out 2      FSM state: 00 IDLE, 01 UP, 10 DOWN, 11 HALT
// -----------------------------------------------------------------------------
module updown_counter_fsm #(
   parameter int WIDTH    = 3,
   parameter int MAX      = 2**WIDTH - 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             P,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             gray,
   output logic [WIDTH-1:0] y,
   output logic             tc,
   output logic [1:0]       st
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic             SAT_V  = (SATURATE != 0);

   // Binary to reflected Gray code.
   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ {1'b0, b[WIDTH-1:1]};
   endfunction

   logic [WIDTH-1:0] cnt_r;
   state_t           state_r;
   logic             tc_r;

   logic [WIDTH-1:0] cnt_nxt_s;
   state_t           state_nxt_s;
   logic             tc_nxt_s;
   state_t           state_hold_s;

   // State the FSM keeps when nothing else moves it; HALT is not a legal
   // resting state in wrap mode, so it recovers to IDLE.
   always_comb begin
      state_hold_s = state_r;
      case (state_r)
         ST_IDLE: state_hold_s = ST_IDLE;
         ST_UP:   state_hold_s = ST_UP;
         ST_DOWN: state_hold_s = ST_DOWN;
         ST_HALT: begin
            if (SAT_V) begin
               state_hold_s = ST_HALT;
            end else begin
               state_hold_s = ST_IDLE;
            end
         end
         default: state_hold_s = ST_IDLE;
      endcase
   end

   // Next-state, next-count and terminal-count decode; load beats count.
   // A HALT exit needs no special casing: at a held boundary, stepping toward
   // it re-enters the saturate-hold path and stepping away is a normal step.
   always_comb begin
      cnt_nxt_s   = cnt_r;
      state_nxt_s = state_hold_s;
      tc_nxt_s    = 1'b0;
      if (load) begin
         if (d > MAX_V) begin
            cnt_nxt_s = MAX_V;
         end else begin
            cnt_nxt_s = d;
         end
         state_nxt_s = ST_IDLE;
         tc_nxt_s    = 1'b0;
      end else if (en) begin
         if (!P) begin
            if (cnt_r != MAX_V) begin
               cnt_nxt_s   = cnt_r + ONE_V;
               state_nxt_s = ST_UP;
               tc_nxt_s    = (cnt_r + ONE_V == MAX_V);
            end else if (SAT_V) begin
               cnt_nxt_s   = MAX_V;
               state_nxt_s = ST_HALT;
               tc_nxt_s    = 1'b0;
            end else begin
               // Wrap lands on 0, which is not terminal while counting up.
               cnt_nxt_s   = ZERO_V;
               state_nxt_s = ST_UP;
               tc_nxt_s    = 1'b0;
            end
         end else begin
            if (cnt_r != ZERO_V) begin
               cnt_nxt_s   = cnt_r - ONE_V;
               state_nxt_s = ST_DOWN;
               tc_nxt_s    = (cnt_r == ONE_V);
            end else if (SAT_V) begin
               cnt_nxt_s   = ZERO_V;
               state_nxt_s = ST_HALT;
               tc_nxt_s    = 1'b0;
            end else begin
               // Wrap lands on MAX, which is not terminal while counting down.
               cnt_nxt_s   = MAX_V;
               state_nxt_s = ST_DOWN;
               tc_nxt_s    = 1'b0;
            end
         end
      end else begin
         cnt_nxt_s   = cnt_r;
         state_nxt_s = state_hold_s;
         tc_nxt_s    = 1'b0;
      end
   end

   // Count, state and terminal-count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r   <= ZERO_V;
         state_r <= ST_IDLE;
         tc_r    <= 1'b0;
      end else begin
         cnt_r   <= cnt_nxt_s;
         state_r <= state_nxt_s;
         tc_r    <= tc_nxt_s;
      end
   end

   // Output coding is a live decode of the registered count.
   always_comb begin
      if (gray) begin
         y = bin2gray(cnt_r);
      end else begin
         y = cnt_r;
      end
   end

   assign tc = tc_r;
   assign st = state_r;

endmodule

// File: tb/tb_updown_counter_fsm.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_fsm
//
// Directed bench for updown_counter_fsm with three instances:
//   dut 0: defaults (WIDTH=3, MAX=7, SATURATE=0)
//   dut 1: WIDTH=3, MAX=5, SATURATE=0
//   dut 2: WIDTH=3, MAX=7, SATURATE=1
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, so each check sees the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_updown_counter_fsm;

   logic       clk;
   logic       reset_s [3];
   logic       en_s    [3];
   logic       p_s     [3];
   logic       load_s  [3];
   logic [2:0] d_s     [3];
   logic       gray_s  [3];
   logic [2:0] y_s     [3];
   logic       tc_s    [3];
   logic [1:0] st_s    [3];

   int total;
   int bad;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] UP   = 2'b01;
   localparam logic [1:0] DOWN = 2'b10;
   localparam logic [1:0] HALT = 2'b11;

   updown_counter_fsm u_dut0 (
      .clk(clk), .reset(reset_s[0]), .en(en_s[0]), .P(p_s[0]), .load(load_s[0]),
      .d(d_s[0]), .gray(gray_s[0]), .y(y_s[0]), .tc(tc_s[0]), .st(st_s[0])
   );

   updown_counter_fsm #(.WIDTH(3), .MAX(5), .SATURATE(0)) u_dut1 (
      .clk(clk), .reset(reset_s[1]), .en(en_s[1]), .P(p_s[1]), .load(load_s[1]),
      .d(d_s[1]), .gray(gray_s[1]), .y(y_s[1]), .tc(tc_s[1]), .st(st_s[1])
   );

   updown_counter_fsm #(.WIDTH(3), .MAX(7), .SATURATE(1)) u_dut2 (
      .clk(clk), .reset(reset_s[2]), .en(en_s[2]), .P(p_s[2]), .load(load_s[2]),
      .d(d_s[2]), .gray(gray_s[2]), .y(y_s[2]), .tc(tc_s[2]), .st(st_s[2])
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input int k, input string tag,
                          input logic [2:0] ey, input logic etc, input logic [1:0] est);
      chk({tag, ".y"},  {5'd0, y_s[k]},  {5'd0, ey});
      chk({tag, ".tc"}, {7'd0, tc_s[k]}, {7'd0, etc});
      chk({tag, ".st"}, {6'd0, st_s[k]}, {6'd0, est});
   endtask

   // Expected sequences, computed by hand.
   logic [2:0] up8_y   [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
   logic       up8_tc  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [2:0] dn_gray [9] = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010,
                               3'b011, 3'b001, 3'b000, 3'b100};
   logic       dn_tc   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [2:0] m5_y    [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd0, 3'd5, 3'd4};
   logic       m5_tc   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0] m5_st   [10] = '{UP, UP, UP, UP, UP, UP, UP, DOWN, DOWN, DOWN};

   initial begin
      total = 0;
      bad   = 0;
      for (int k = 0; k < 3; k++) begin
         reset_s[k] = 1'b1;
         en_s[k]    = 1'b0;
         p_s[k]     = 1'b0;
         load_s[k]  = 1'b0;
         d_s[k]     = 3'd0;
         gray_s[k]  = 1'b0;
      end

      // Reset state of all instances.
      tick();
      chk_dut(0, "rst0", 3'd0, 1'b0, IDLE);
      chk_dut(1, "rst1", 3'd0, 1'b0, IDLE);
      chk_dut(2, "rst2", 3'd0, 1'b0, IDLE);
      for (int k = 0; k < 3; k++) reset_s[k] = 1'b0;

      // dut0: up-count 9 steps, wraps 7 -> 0.
      en_s[0] = 1'b1;
      p_s[0]  = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk_dut(0, $sformatf("up%0d", i), up8_y[i], up8_tc[i], UP);
      end

      // dut0: reset, then Gray-coded down-count from 0 (wraps to 7 first).
      reset_s[0] = 1'b1;
      tick();
      chk_dut(0, "rst0b", 3'd0, 1'b0, IDLE);
      reset_s[0] = 1'b0;
      gray_s[0]  = 1'b1;
      p_s[0]     = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk_dut(0, $sformatf("gdn%0d", i), dn_gray[i], dn_tc[i], DOWN);
      end
      // Count is now 7; switching coding alters y in the same cycle.
      en_s[0]   = 1'b0;
      gray_s[0] = 1'b0;
      #1;
      chk(".graysw", {5'd0, y_s[0]}, 8'd7);
      tick();
      chk_dut(0, "hold0", 3'd7, 1'b0, DOWN);

      // dut1 (MAX=5): up 7 steps then down 3 steps.
      en_s[1] = 1'b1;
      p_s[1]  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 7) p_s[1] = 1'b1;
         tick();
         chk_dut(1, $sformatf("m5_%0d", i), m5_y[i], m5_tc[i], m5_st[i]);
      end

      // dut1: load with en set, d above MAX clamps to 5.
      load_s[1] = 1'b1;
      d_s[1]    = 3'd7;
      tick();
      chk_dut(1, "ldclamp", 3'd5, 1'b0, IDLE);
      load_s[1] = 1'b0;
      en_s[1]   = 1'b0;
      tick();
      chk_dut(1, "ldhold", 3'd5, 1'b0, IDLE);

      // dut1: bring count to 4 counting up, then reset wins over load.
      load_s[1] = 1'b1;
      d_s[1]    = 3'd3;
      tick();
      chk_dut(1, "ld3", 3'd3, 1'b0, IDLE);
      load_s[1] = 1'b0;
      en_s[1]   = 1'b1;
      p_s[1]    = 1'b0;
      tick();
      chk_dut(1, "to4", 3'd4, 1'b0, UP);
      reset_s[1] = 1'b1;
      load_s[1]  = 1'b1;
      d_s[1]     = 3'd3;
      tick();
      chk_dut(1, "midrst", 3'd0, 1'b0, IDLE);
      reset_s[1] = 1'b0;
      load_s[1]  = 1'b0;
      tick();
      chk_dut(1, "afterrst", 3'd1, 1'b0, UP);

      // dut2 (saturate): load 6, up 3 steps saturates at 7.
      load_s[2] = 1'b1;
      d_s[2]    = 3'd6;
      tick();
      chk_dut(2, "sld6", 3'd6, 1'b0, IDLE);
      load_s[2] = 1'b0;
      en_s[2]   = 1'b1;
      p_s[2]    = 1'b0;
      tick();
      chk_dut(2, "sat0", 3'd7, 1'b1, UP);
      tick();
      chk_dut(2, "sat1", 3'd7, 1'b0, HALT);
      tick();
      chk_dut(2, "sat2", 3'd7, 1'b0, HALT);
      // Reverse out of HALT: immediate step down.
      p_s[2] = 1'b1;
      tick();
      chk_dut(2, "satexit", 3'd6, 1'b0, DOWN);
      // Down to 0 (values 5..0), then hold at 0 in HALT.
      for (int i = 5; i >= 0; i--) begin
         tick();
         chk_dut(2, $sformatf("sdn%0d", i), 3'(i), (i == 0) ? 1'b1 : 1'b0, DOWN);
      end
      tick();
      chk_dut(2, "satlo", 3'd0, 1'b0, HALT);
      en_s[2] = 1'b0;
      tick();
      chk_dut(2, "halthold", 3'd0, 1'b0, HALT);
      en_s[2] = 1'b1;
      p_s[2]  = 1'b0;
      tick();
      chk_dut(2, "satloexit", 3'd1, 1'b0, UP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
